// File: rtl/apix_link_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package   : apix_link_pkg
// Purpose   : Shared constants, framer state encoding and CRC helper for the
//             APIX link scheduler.
// Contents  : SYNC_BYTE, TYPE_PIX, TYPE_CTRL, IDLE_BYTE, apix_state_e,
//             frame_crc()
// Revision  : 1.0 - initial release
// ============================================================================
package apix_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hFF;
  localparam logic [7:0] TYPE_PIX  = 8'h01;
  localparam logic [7:0] TYPE_CTRL = 8'h02;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    TYPE = 3'd2,
    DATA = 3'd3,
    CRC  = 3'd4
  } apix_state_e;

  // Frame check byte: XOR of TYPE and the three payload bytes (SYNC excluded).
  function automatic logic [7:0] frame_crc(input logic [7:0] type_byte,
                                           input logic [23:0] payload);
    return type_byte ^ payload[23:16] ^ payload[15:8] ^ payload[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/apix_link_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : apix_link_scheduler_if
// Purpose   : Bundles the two requester handshakes and the serializer byte
//             handshake of the APIX link scheduler.
// Signals   : pix_valid/pix_data/pix_ready   - pixel requester
//             ctrl_valid/ctrl_data/ctrl_ready - sideband control requester
//             link_byte/link_valid/link_ready - byte stream to serializer
// Modports  : master - scheduler side; slave - requester/serializer side
// Revision  : 1.0 - initial release
// ============================================================================
interface apix_link_scheduler_if;

  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        ctrl_valid;
  logic [23:0] ctrl_data;
  logic        ctrl_ready;
  logic [7:0]  link_byte;
  logic        link_valid;
  logic        link_ready;

  modport master (
    input  pix_valid, pix_data, ctrl_valid, ctrl_data, link_ready,
    output pix_ready, ctrl_ready, link_byte, link_valid
  );

  modport slave (
    output pix_valid, pix_data, ctrl_valid, ctrl_data, link_ready,
    input  pix_ready, ctrl_ready, link_byte, link_valid
  );

endinterface
`default_nettype wire

// File: rtl/apix_link_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module    : apix_sched_arb
// Purpose   : Per-frame grant between pixel and control requesters. Pixel wins
//             by default; control wins when pixel is idle or after CTRL_SLOT
//             consecutive pixel grants taken while control was waiting.
// Ports     : clk, rst_n (async, active-low)
//             en          - scheduler able to accept a frame this cycle
//             pix_valid   - pixel request
//             ctrl_valid  - control request
//             grant_pix   - pixel granted (combinational)
//             grant_ctrl  - control granted (combinational)
// Params    : CTRL_SLOT   - max consecutive pixel grants while ctrl pending
// Revision  : 1.0 - initial release
// ============================================================================
module apix_sched_arb #(
  parameter int CTRL_SLOT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic pix_valid,
  input  logic ctrl_valid,
  output logic grant_pix,
  output logic grant_ctrl
);

  localparam int            CW     = $clog2(CTRL_SLOT + 1);
  localparam logic [CW-1:0] C_SLOT = CW'(CTRL_SLOT);

  logic [CW-1:0] r_starve;
  logic          w_ctrl_win;
  logic          w_any_grant;

  assign w_ctrl_win  = ctrl_valid & (~pix_valid | (r_starve == C_SLOT));
  assign grant_ctrl  = en & w_ctrl_win;
  assign grant_pix   = en & pix_valid & ~w_ctrl_win;
  assign w_any_grant = grant_ctrl | grant_pix;

  // Counts pixel grants that overtook a waiting control word. Any grant seen
  // with control idle means nobody was starved, so the count restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (grant_ctrl || (w_any_grant && !ctrl_valid)) begin
      r_starve <= '0;
    end else if (grant_pix && (r_starve != C_SLOT)) begin
      r_starve <= r_starve + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/apix_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module    : apix_link_scheduler
// Purpose   : Shares the APIX serial link between the pixel stream and the
//             sideband control channel. One requester is granted per frame;
//             the framer then emits SYNC(0xFF), TYPE, 3 payload bytes (MSB
//             first) and an XOR CRC byte to the link serializer.
// Ports     : clk, rst_n (async, active-low)
//             link        - apix_link_scheduler_if.master (requesters + link)
//             busy        - frame in progress
//             frame_done  - pulse the cycle after the CRC byte is taken
//             frames_sent - saturating count of completed frames
// Params    : CTRL_SLOT   - max consecutive pixel frames while ctrl pending
//             CNT_W       - width of frames_sent
// Options   : APIX_IDLE_FILL_EN - drive 0x00 fill bytes with link_valid=1
//             while idle and no grant is being made.
// Revision  : 1.0 - initial release
// ============================================================================
module apix_link_scheduler
  import apix_link_pkg::*;
#(
  parameter int CTRL_SLOT = 8,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apix_link_scheduler_if.master link,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      frames_sent
);

  apix_state_e r_state;
  apix_state_e w_state_nxt;

  logic [7:0]       r_type;
  logic [23:0]      r_payload;
  logic [7:0]       r_crc;
  logic [1:0]       r_idx;
  logic [1:0]       w_idx_nxt;
  logic             r_frame_done;
  logic [CNT_W-1:0] r_frames_sent;

  logic       w_arb_en;
  logic       w_grant_pix;
  logic       w_grant_ctrl;
  logic       w_grant;
  logic       w_take;
  logic       w_crc_take;
  logic       w_link_valid;
  logic [7:0] w_link_byte;

  // No grant while reset is held, so the requester readies stay low.
  assign w_arb_en = rst_n & (r_state == IDLE);

  apix_sched_arb #(
    .CTRL_SLOT (CTRL_SLOT)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (w_arb_en),
    .pix_valid  (link.pix_valid),
    .ctrl_valid (link.ctrl_valid),
    .grant_pix  (w_grant_pix),
    .grant_ctrl (w_grant_ctrl)
  );

  assign w_grant         = w_grant_pix | w_grant_ctrl;
  assign link.pix_ready  = w_grant_pix;
  assign link.ctrl_ready = w_grant_ctrl;
  assign w_take          = w_link_valid & link.link_ready;

  // --------------------------------------------------------------------------
  // Framer FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Framer FSM: next state and link outputs. The link byte is a pure function
  // of registered state, so it cannot change while the serializer stalls.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_link_valid = 1'b0;
    w_link_byte  = IDLE_BYTE;
    w_crc_take   = 1'b0;
    case (r_state)
      IDLE: begin
`ifdef APIX_IDLE_FILL_EN
        // A fill byte is abandoned the moment a grant is made.
        w_link_valid = rst_n & ~w_grant;
`endif
        if (w_grant) begin
          w_state_nxt = SYNC;
        end
      end
      SYNC: begin
        w_link_valid = 1'b1;
        w_link_byte  = SYNC_BYTE;
        if (w_take) begin
          w_state_nxt = TYPE;
        end
      end
      TYPE: begin
        w_link_valid = 1'b1;
        w_link_byte  = r_type;
        if (w_take) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 2'd0;
        end
      end
      DATA: begin
        w_link_valid = 1'b1;
        case (r_idx)
          2'd0:    w_link_byte = r_payload[23:16];
          2'd1:    w_link_byte = r_payload[15:8];
          default: w_link_byte = r_payload[7:0];
        endcase
        if (w_take) begin
          if (r_idx == 2'd2) begin
            w_state_nxt = CRC;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
          end
        end
      end
      CRC: begin
        w_link_valid = 1'b1;
        w_link_byte  = r_crc;
        if (w_take) begin
          w_state_nxt = IDLE;
          w_crc_take  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Payload / CRC capture and frame statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type        <= IDLE_BYTE;
      r_payload     <= '0;
      r_crc         <= '0;
      r_idx         <= '0;
      r_frame_done  <= 1'b0;
      r_frames_sent <= '0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_frame_done <= w_crc_take;
      if (w_grant) begin
        r_type    <= w_grant_ctrl ? TYPE_CTRL : TYPE_PIX;
        r_payload <= w_grant_ctrl ? link.ctrl_data : link.pix_data;
        r_crc     <= frame_crc(w_grant_ctrl ? TYPE_CTRL : TYPE_PIX,
                               w_grant_ctrl ? link.ctrl_data : link.pix_data);
      end
      if (w_crc_take && (r_frames_sent != {CNT_W{1'b1}})) begin
        r_frames_sent <= r_frames_sent + CNT_W'(1);
      end
    end
  end

  assign link.link_valid = w_link_valid;
  assign link.link_byte  = w_link_byte;
  assign busy            = (r_state != IDLE);
  assign frame_done      = r_frame_done;
  assign frames_sent     = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_apix_link_scheduler.sv
`default_nettype none
// ============================================================================
// Module    : tb_apix_link_scheduler
// Purpose   : Self-checking bench for apix_link_scheduler (CTRL_SLOT=8,
//             CNT_W=4). Expected link bytes are queued when a frame is
//             granted and compared as the serializer takes them.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_apix_link_scheduler;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef APIX_IDLE_FILL_EN
  localparam logic FILL = 1'b1;
`else
  localparam logic FILL = 1'b0;
`endif

  typedef struct {
    logic        is_ctrl;
    logic [23:0] data;
    logic [7:0]  crc;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frames_sent;

  apix_link_scheduler_if bus ();

  always #5 clk = ~clk;

  apix_link_scheduler #(
    .CTRL_SLOT (8),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link        (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .frames_sent (frames_sent)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         lr_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Serializer: always ready, or random back-pressure.
  initial begin
    bus.link_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.link_ready = (lr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard compare, stall stability, frames_sent model.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;
  int         model_cnt  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", bus.link_byte, prev_byte);
      if (busy && bus.link_valid && bus.link_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.link_byte);
        end else begin
          check("link_byte", bus.link_byte, sb.pop_front());
        end
      end
      prev_stall = busy && bus.link_valid && !bus.link_ready;
      prev_byte  = bus.link_byte;
      if (frame_done) begin
        if (model_cnt < CNT_MAX) model_cnt++;
        check("frames_sent", frames_sent, model_cnt);
      end
    end
  end

  task automatic push_frame(input logic is_ctrl, input logic [23:0] d, input logic [7:0] crc);
    sb.push_back(8'hFF);
    sb.push_back(is_ctrl ? 8'h02 : 8'h01);
    sb.push_back(d[23:16]);
    sb.push_back(d[15:8]);
    sb.push_back(d[7:0]);
    sb.push_back(crc);
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_now("frame_done_wait");
  endtask

  // Called just after a rising edge; returns just after the frame_done negedge.
  task automatic send(input logic is_ctrl, input logic [23:0] d, input logic [7:0] crc);
    bit got = 0;
    push_frame(is_ctrl, d, crc);
    if (is_ctrl) begin
      bus.ctrl_valid = 1'b1;
      bus.ctrl_data  = d;
    end else begin
      bus.pix_valid = 1'b1;
      bus.pix_data  = d;
    end
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (is_ctrl ? bus.ctrl_ready : bus.pix_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) fail_now("grant_wait");
    check("other_ready", is_ctrl ? bus.pix_ready : bus.ctrl_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.pix_valid  = 1'b0;
    bus.ctrl_valid = 1'b0;
    wait_done();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 24'h123456, 8'h71};
    vecs[1] = '{1'b1, 24'hA5A5A5, 8'hA7};
    vecs[2] = '{1'b0, 24'h000000, 8'h01};
    vecs[3] = '{1'b1, 24'hFFFFFF, 8'hFD};
    vecs[4] = '{1'b0, 24'h0F0F0F, 8'h0E};
    vecs[5] = '{1'b1, 24'h123456, 8'h72};
    vecs[6] = '{1'b0, 24'h800001, 8'h80};

    bus.pix_valid  = 1'b1;   // readies must stay low while reset is held
    bus.pix_data   = 24'h0;
    bus.ctrl_valid = 1'b0;
    bus.ctrl_data  = 24'h0;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",        busy, 1'b0);
    check("rst_link_valid",  bus.link_valid, 1'b0);
    check("rst_link_byte",   bus.link_byte, 8'h00);
    check("rst_frame_done",  frame_done, 1'b0);
    check("rst_frames_sent", frames_sent, 0);
    check("rst_pix_ready",   bus.pix_ready, 1'b0);
    check("rst_ctrl_ready",  bus.ctrl_ready, 1'b0);
    bus.pix_valid = 1'b0;
    rst_n         = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven single frames with an idle-gap check after each.
    foreach (vecs[i]) begin
      send(vecs[i].is_ctrl, vecs[i].data, vecs[i].crc);
      @(negedge clk);
      check("gap_busy",       busy, 1'b0);
      check("gap_link_valid", bus.link_valid, FILL);
      check("gap_link_byte",  bus.link_byte, 8'h00);
      @(posedge clk);
      #1;
    end

    // Random serializer back-pressure.
    lr_mode = 1;
    repeat (3) begin
      send(1'b0, 24'h123456, 8'h71);
      @(posedge clk);
      #1;
    end
    lr_mode = 0;
    @(posedge clk);
    #1;

    // Both requesters held: 8 pixel frames then 1 control frame, repeating.
    begin
      int consec = 0;
      bus.pix_data   = 24'h0A0B0C;
      bus.ctrl_data  = 24'hC0FFEE;
      bus.pix_valid  = 1'b1;
      bus.ctrl_valid = 1'b1;
      for (int g = 0; g < 27; g++) begin
        bit got = 0;
        logic exp_ctrl;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (bus.pix_ready || bus.ctrl_ready) begin
            got = 1;
            break;
          end
        end
        if (!got) begin
          fail_now("arb_grant_wait");
          break;
        end
        exp_ctrl = (consec == 8);
        check("arb_ctrl_ready", bus.ctrl_ready, exp_ctrl);
        check("arb_pix_ready",  bus.pix_ready, !exp_ctrl);
        push_frame(exp_ctrl, exp_ctrl ? 24'hC0FFEE : 24'h0A0B0C,
                   exp_ctrl ? 8'hD3 : 8'h0C);
        consec = exp_ctrl ? 0 : consec + 1;
        @(posedge clk);
        #1;
      end
      bus.pix_valid  = 1'b0;
      bus.ctrl_valid = 1'b0;
      wait_done();
      check("sat_frames_sent", frames_sent, CNT_MAX);
      @(posedge clk);
      #1;
    end

    // Reset after the first payload byte has been taken.
    begin
      bit got = 0;
      bus.pix_data  = 24'h123456;
      bus.pix_valid = 1'b1;
      push_frame(1'b0, 24'h123456, 8'h71);
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (bus.pix_ready) begin
          got = 1;
          break;
        end
      end
      if (!got) fail_now("rst_grant_wait");
      @(posedge clk);
      #1;
      bus.pix_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid_busy",        busy, 1'b0);
      check("mid_link_valid",  bus.link_valid, 1'b0);
      check("mid_link_byte",   bus.link_byte, 8'h00);
      check("mid_frame_done",  frame_done, 1'b0);
      check("mid_frames_sent", frames_sent, 0);
      check("mid_sb_left",     sb.size(), 3);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(1'b0, 24'h123456, 8'h71);
      check("post_rst_frames_sent", frames_sent, 1);
    end

    repeat (4) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
